// File: rtl/spi_cfg_controller.sv
// SPI configuration command sequencer: frames received bytes into write/read packets
// and drives single-cycle register-bank strobes plus the read-back byte stream for MISO.
module spi_cfg_controller #(
    parameter int ADDR_W = 7  // must be <= 7: the address comes from command bits [6:0]
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    input  logic              spi_ss_n,
    output logic [ADDR_W-1:0] cfg_addr,
    output logic [7:0]        cfg_wdata,
    output logic              cfg_we,
    output logic              cfg_re,
    input  logic [7:0]        cfg_rdata,
    output logic [7:0]        tx_byte,
    output logic              tx_valid,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_REQ,
        RD_CAP,
        RD_HOLD
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic              ss_meta;
    logic              ss_sync;
    logic              ss_prev;
    logic              frame_end;

    // Idle-high reset values keep a reset from looking like a select release.
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_meta <= 1'b1;
            ss_sync <= 1'b1;
            ss_prev <= 1'b1;
        end else begin
            ss_meta <= spi_ss_n;
            ss_sync <= ss_meta;
            ss_prev <= ss_sync;
        end
    end

    assign frame_end = ss_sync & ~ss_prev;

    always_ff @(posedge clk) begin
        // NOTE: strobes default low every cycle so each set below is exactly one cycle wide.
        cfg_we   <= 1'b0;
        cfg_re   <= 1'b0;
        tx_valid <= 1'b0;
        overrun  <= 1'b0;
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            cfg_addr  <= '0;
            cfg_wdata <= '0;
            tx_byte   <= '0;
            busy      <= 1'b0;
        end else if (frame_end) begin
            // Select release wins over a coincident byte and any pending read-back.
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (byte_valid) begin
                        addr <= byte_in[ADDR_W-1:0];
                        busy <= 1'b1;
                        if (byte_in[7]) begin
                            state <= WRITE;
                        end else begin
                            // Read request is issued on entry so cfg_re lands one cycle after the command.
                            state    <= RD_REQ;
                            cfg_re   <= 1'b1;
                            cfg_addr <= byte_in[ADDR_W-1:0];
                        end
                    end
                end
                WRITE: begin
                    if (byte_valid) begin
                        cfg_we    <= 1'b1;
                        cfg_addr  <= addr;
                        cfg_wdata <= byte_in;
                        addr      <= addr + ADDR_W'(1);
                    end
                end
                RD_REQ: begin
                    state   <= RD_CAP;
                    overrun <= byte_valid;
                end
                RD_CAP: begin
                    tx_byte  <= cfg_rdata;
                    tx_valid <= 1'b1;
                    addr     <= addr + ADDR_W'(1);
                    state    <= RD_HOLD;
                    overrun  <= byte_valid;
                end
                RD_HOLD: begin
                    // A dummy byte means the previous tx byte has gone out; fetch the next one.
                    if (byte_valid) begin
                        state    <= RD_REQ;
                        cfg_re   <= 1'b1;
                        cfg_addr <= addr;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
